// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder:
// address regions, timer register offsets and bit positions.
package mem_io_responder_pkg;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_SW  = 4'h3;
    localparam logic [3:0] REG_TMR = 4'h4;

    localparam logic [1:0] TMR_LOAD   = 2'd0;
    localparam logic [1:0] TMR_COUNT  = 2'd1;
    localparam logic [1:0] TMR_CTRL   = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int STATUS_EXP = 0;

endpackage

// File: rtl/mem_io_responder_tick_timer.sv
// Prescaled down-counter with LOAD/COUNT/CTRL/STATUS registers
// and a combinational read mux over the four offsets.
module tick_timer
    import mem_io_responder_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [15:0]   load_q;
    logic [15:0]   count_q;
    logic          en_q;
    logic          auto_q;
    logic          exp_q;
    logic [PW-1:0] ps_q;

    logic tick;
    logic wr_load;
    logic wr_ctrl;
    logic wr_stat;

    assign tick    = en_q && (ps_q == PS_LAST);
    assign wr_load = we && (offset == TMR_LOAD);
    assign wr_ctrl = we && (offset == TMR_CTRL);
    assign wr_stat = we && (offset == TMR_STATUS);
    assign irq     = exp_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
            ps_q    <= '0;
        end else begin
            if (en_q)
                ps_q <= tick ? '0 : ps_q + 1'b1;
            // clear first so a same-edge expiry below wins
            if (wr_stat && wdata[STATUS_EXP])
                exp_q <= 1'b0;
            if (wr_load) begin
                load_q  <= wdata;
                count_q <= wdata;
                ps_q    <= '0;
            end else if (tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - 16'd1;
                end else begin
                    exp_q <= 1'b1;
                    if (auto_q)
                        count_q <= load_q;
                    else
                        en_q <= 1'b0;
                end
            end
            if (wr_ctrl) begin
                en_q   <= wdata[CTRL_EN];
                auto_q <= wdata[CTRL_AUTO];
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (offset)
            TMR_LOAD:   rdata = load_q;
            TMR_COUNT:  rdata = count_q;
            TMR_CTRL: begin
                rdata[CTRL_EN]   = en_q;
                rdata[CTRL_AUTO] = auto_q;
            end
            TMR_STATUS: rdata[STATUS_EXP] = exp_q;
        endcase
    end

endmodule

// File: rtl/mem_io_responder.sv
// Single bus target for the processor: mirrored RAM, LED register,
// synchronized switches and a tick timer, with one-cycle read latency.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_AW   = 8,
    parameter int LED_W    = 10,
    parameter int SW_W     = 10,
    parameter int PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      ADDR,
    input  logic [15:0]      DOUT,
    input  logic             W,
    output logic [15:0]      DIN,
    input  logic [SW_W-1:0]  SW,
    output logic [LED_W-1:0] LEDR,
    output logic             TIMER_IRQ
);

    logic [3:0]      region;
    logic            ram_we;
    logic            led_we;
    logic            tmr_we;
    logic [15:0]     ram [2**RAM_AW];
    logic [15:0]     ram_q;
    logic            ram_sel_q;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic [15:0]     tmr_rdata;
    logic [15:0]     io_rd;
    logic [15:0]     io_q;
    logic            unused_addr;

    assign region      = ADDR[15:12];
    assign ram_we      = W && !Reset && (region == REG_RAM);
    assign led_we      = W && (region == REG_LED);
    assign tmr_we      = W && (region == REG_TMR);
    assign unused_addr = ^ADDR[11:RAM_AW];

    // Reset-free array so synthesis maps it onto block RAM
    always_ff @(posedge Clock) begin
        if (ram_we)
            ram[ADDR[RAM_AW-1:0]] <= DOUT;
        ram_q <= ram[ADDR[RAM_AW-1:0]];
    end

    tick_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .we    (tmr_we),
        .offset(ADDR[1:0]),
        .wdata (DOUT),
        .rdata (tmr_rdata),
        .irq   (TIMER_IRQ)
    );

    always_comb begin
        io_rd = '0;
        case (region)
            REG_LED: io_rd = 16'(LEDR);
            REG_SW:  io_rd = 16'(sw_sync);
            REG_TMR: io_rd = tmr_rdata;
            default: io_rd = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            LEDR      <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            io_q      <= '0;
            ram_sel_q <= 1'b0;
        end else begin
            if (led_we)
                LEDR <= DOUT[LED_W-1:0];
            sw_meta   <= SW;
            sw_sync   <= sw_meta;
            io_q      <= io_rd;
            ram_sel_q <= (region == REG_RAM);
        end
    end

    assign DIN = ram_sel_q ? ram_q : io_q;

endmodule
